// File: rtl/jtag_host_shifter_pkg.sv
// Shared types for the JTAG host shifter: FSM states, command record, divider limit.
// JTAG_HOST_TRST_EN adds the TRST state and the trst field of the command.
package jtag_host_pkg;

    localparam int CLK_DIV_MIN = 2;
    // Command record is sized for the widest supported command.
    localparam int CMD_DATA_W  = 32;
    localparam int CMD_LEN_W   = 5;

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
`ifdef JTAG_HOST_TRST_EN
        , TRST
`endif
    } state_t;

    typedef struct packed {
        logic [CMD_LEN_W-1:0]  len;
        logic [CMD_DATA_W-1:0] tms;
        logic [CMD_DATA_W-1:0] tdi;
`ifdef JTAG_HOST_TRST_EN
        logic                  trst;
`endif
    } cmd_t;

endpackage

// File: rtl/jtag_host_shifter_if.sv
// Command/response channels of the JTAG host shifter (valid/ready on both sides).
// JTAG_HOST_TRST_EN adds cmd_trst_i.
interface jtag_host_shifter_if #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 5
);
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [LEN_W-1:0]  cmd_len_i;
    logic [DATA_W-1:0] cmd_tms_i;
    logic [DATA_W-1:0] cmd_tdi_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_tdo_o;
`ifdef JTAG_HOST_TRST_EN
    logic              cmd_trst_i;
`endif

    modport master (
        input  cmd_ready_o, rsp_valid_o, rsp_tdo_o,
        output cmd_valid_i, cmd_len_i, cmd_tms_i, cmd_tdi_i, rsp_ready_i
`ifdef JTAG_HOST_TRST_EN
        , cmd_trst_i
`endif
    );

    modport slave (
        output cmd_ready_o, rsp_valid_o, rsp_tdo_o,
        input  cmd_valid_i, cmd_len_i, cmd_tms_i, cmd_tdi_i, rsp_ready_i
`ifdef JTAG_HOST_TRST_EN
        , cmd_trst_i
`endif
    );
endinterface

// File: rtl/jtag_host_shifter_tck_gen.sv
// TCK half-period timer: counts clk cycles while enabled and strobes half_done
// on the last cycle of every CLK_DIV-cycle half-period.
module jtag_host_tck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic half_done
);
    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt_q;

    assign half_done = en && (cnt_q == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (clear || !en || half_done)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + CNT_W'(1);
    end
endmodule

// File: rtl/jtag_host_shifter.sv
// JTAG host: shifts TMS/TDI bit vectors into a TAP with a divided TCK and returns TDO.
// JTAG_HOST_TRST_EN adds TRST-pulse commands (cmd_trst_i, trst_no).
module jtag_host_shifter
    import jtag_host_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 5,
    parameter int CLK_DIV = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    jtag_host_shifter_if.slave   bus,
    output logic                 busy_o,
    output logic                 tck_o,
    output logic                 tms_o,
    output logic                 tdi_o,
    input  logic                 tdo_i
`ifdef JTAG_HOST_TRST_EN
    , output logic               trst_no
`endif
);
    generate
        if (CLK_DIV < CLK_DIV_MIN) begin : g_bad_div
            $error("CLK_DIV must be >= %0d", CLK_DIV_MIN);
        end
        if (LEN_W != $clog2(DATA_W)) begin : g_bad_len
            $error("LEN_W must equal clog2(DATA_W)");
        end
        if (DATA_W > CMD_DATA_W) begin : g_bad_data
            $error("DATA_W exceeds the command record width");
        end
    endgenerate

    state_t            state_q, state_n;
    cmd_t              cmd_q, cmd_n;
    logic [LEN_W-1:0]  bit_cnt_q, bit_cnt_n;
    logic [DATA_W-1:0] tdo_q, tdo_n;
    logic              tck_q, tck_n, tms_q, tms_n, tdi_q, tdi_n;
    logic              rsp_valid_q, rsp_valid_n;
    logic              accept, half_done, tck_en;
    logic [DATA_W-1:0] tms_vec, tdi_vec;
`ifdef JTAG_HOST_TRST_EN
    logic              trst_no_q, trst_no_n;
`endif

    assign accept  = (state_q == IDLE) && bus.cmd_valid_i;
    assign tms_vec = cmd_q.tms[DATA_W-1:0];
    assign tdi_vec = cmd_q.tdi[DATA_W-1:0];
`ifdef JTAG_HOST_TRST_EN
    assign tck_en  = (state_q == LOW) || (state_q == HIGH) || (state_q == TRST);
`else
    assign tck_en  = (state_q == LOW) || (state_q == HIGH);
`endif

    jtag_host_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
        .clk       (clk_i),
        .rst       (rst_i),
        .en        (tck_en),
        .clear     (accept),
        .half_done (half_done)
    );

    always_comb begin
        state_n     = state_q;
        cmd_n       = cmd_q;
        bit_cnt_n   = bit_cnt_q;
        tdo_n       = tdo_q;
        tck_n       = tck_q;
        tms_n       = tms_q;
        tdi_n       = tdi_q;
        rsp_valid_n = rsp_valid_q;
`ifdef JTAG_HOST_TRST_EN
        trst_no_n   = 1'b1;
`endif
        case (state_q)
            IDLE: if (bus.cmd_valid_i) begin
                cmd_n.len = bus.cmd_len_i;
                cmd_n.tms = bus.cmd_tms_i;
                cmd_n.tdi = bus.cmd_tdi_i;
                tdo_n     = '0;
                bit_cnt_n = '0;
`ifdef JTAG_HOST_TRST_EN
                cmd_n.trst = bus.cmd_trst_i;
                if (bus.cmd_trst_i) begin
                    state_n   = TRST;
                    tms_n     = 1'b1;
                    trst_no_n = 1'b0;
                end else
`endif
                begin
                    // First bit is on the pins from the first LOW cycle.
                    state_n = LOW;
                    tms_n   = bus.cmd_tms_i[0];
                    tdi_n   = bus.cmd_tdi_i[0];
                end
            end
            LOW: if (half_done) begin
                state_n            = HIGH;
                tck_n              = 1'b1;
                tdo_n[bit_cnt_q]   = tdo_i;
            end
            HIGH: if (half_done) begin
                tck_n = 1'b0;
                if (bit_cnt_q == cmd_q.len[LEN_W-1:0]) begin
                    state_n     = DONE;
                    rsp_valid_n = 1'b1;
                end else begin
                    bit_cnt_n = bit_cnt_q + LEN_W'(1);
                    state_n   = LOW;
                    tms_n     = tms_vec[bit_cnt_n];
                    tdi_n     = tdi_vec[bit_cnt_n];
                end
            end
            DONE: if (bus.rsp_ready_i) begin
                state_n     = IDLE;
                rsp_valid_n = 1'b0;
            end
`ifdef JTAG_HOST_TRST_EN
            // Two half-periods of TRST low; bit_cnt[0] marks the second one.
            TRST: begin
                trst_no_n = ~cmd_q.trst;
                if (half_done) begin
                    if (bit_cnt_q[0]) begin
                        state_n     = DONE;
                        rsp_valid_n = 1'b1;
                        trst_no_n   = 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt_q + LEN_W'(1);
                    end
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            bit_cnt_q   <= '0;
            tdo_q       <= '0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
`ifdef JTAG_HOST_TRST_EN
            trst_no_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_n;
            cmd_q       <= cmd_n;
            bit_cnt_q   <= bit_cnt_n;
            tdo_q       <= tdo_n;
            tck_q       <= tck_n;
            tms_q       <= tms_n;
            tdi_q       <= tdi_n;
            rsp_valid_q <= rsp_valid_n;
`ifdef JTAG_HOST_TRST_EN
            trst_no_q   <= trst_no_n;
`endif
        end
    end

    assign bus.cmd_ready_o = (state_q == IDLE);
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_tdo_o   = tdo_q;
    assign busy_o          = (state_q != IDLE);
    assign tck_o           = tck_q;
    assign tms_o           = tms_q;
    assign tdi_o           = tdi_q;
`ifdef JTAG_HOST_TRST_EN
    assign trst_no         = trst_no_q;
`endif
endmodule

// File: tb/tb_jtag_host_shifter.sv
// Self-checking bench for jtag_host_shifter: vector table, TAP model, corner sequences.
// Define JTAG_HOST_TRST_EN to also exercise the TRST command.
module tb_jtag_host_shifter;
    localparam int DATA_W  = 32;
    localparam int LEN_W   = 5;
    localparam int CLK_DIV = 4;
    localparam logic [31:0] IDCODE = 32'h10102001;

    localparam logic [3:0] TLR = 4'd0, RTI = 4'd1, SEL_DR = 4'd2, CAP_DR = 4'd3,
        SH_DR = 4'd4, EX1_DR = 4'd5, PAUSE_DR = 4'd6, EX2_DR = 4'd7, UPD_DR = 4'd8,
        SEL_IR = 4'd9, CAP_IR = 4'd10, SH_IR = 4'd11, EX1_IR = 4'd12, PAUSE_IR = 4'd13,
        EX2_IR = 4'd14, UPD_IR = 4'd15;

    typedef struct {
        logic [4:0]  len;
        logic [31:0] tms;
        logic [31:0] tdi;
        logic [31:0] pat;
    } vec_t;

    typedef struct {
        logic [31:0] tdo;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, tck, tms, tdi, tdo;
`ifdef JTAG_HOST_TRST_EN
    logic trst_n;
`endif

    always #5 clk = ~clk;

    jtag_host_shifter_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    jtag_host_shifter #(.DATA_W(DATA_W), .LEN_W(LEN_W), .CLK_DIV(CLK_DIV)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus    (bus),
        .busy_o (busy),
        .tck_o  (tck),
        .tms_o  (tms),
        .tdi_o  (tdi),
        .tdo_i  (tdo)
`ifdef JTAG_HOST_TRST_EN
        , .trst_no (trst_n)
`endif
    );

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vecs[6];

    // TDO source: either a per-command bit pattern or a small TAP model.
    logic        use_tap = 1'b0;
    logic [31:0] pat_cur = '0;
    int          base = 0;
    int          rise_cnt = 0;
    logic [3:0]  tap_st = TLR;
    logic [31:0] tap_dr = '0;

    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
        case (s)
            TLR:      return m ? TLR    : RTI;
            RTI:      return m ? SEL_DR : RTI;
            SEL_DR:   return m ? SEL_IR : CAP_DR;
            CAP_DR:   return m ? EX1_DR : SH_DR;
            SH_DR:    return m ? EX1_DR : SH_DR;
            EX1_DR:   return m ? UPD_DR : PAUSE_DR;
            PAUSE_DR: return m ? EX2_DR : PAUSE_DR;
            EX2_DR:   return m ? UPD_DR : SH_DR;
            UPD_DR:   return m ? SEL_DR : RTI;
            SEL_IR:   return m ? TLR    : CAP_IR;
            CAP_IR:   return m ? EX1_IR : SH_IR;
            SH_IR:    return m ? EX1_IR : SH_IR;
            EX1_IR:   return m ? UPD_IR : PAUSE_IR;
            PAUSE_IR: return m ? EX2_IR : PAUSE_IR;
            EX2_IR:   return m ? UPD_IR : SH_IR;
            default:  return m ? SEL_DR : RTI;
        endcase
    endfunction

    always @(posedge tck) begin
        if (tap_st == CAP_DR)
            tap_dr <= IDCODE;
        else if (tap_st == SH_DR)
            tap_dr <= {tdi, tap_dr[31:1]};
        tap_st   <= tap_next(tap_st, tms);
        rise_cnt <= rise_cnt + 1;
    end

    always_comb begin
        logic [4:0] idx;
        idx = 5'(rise_cnt - base);
        if (use_tap)
            tdo = (tap_st == SH_DR) ? tap_dr[0] : 1'b0;
        else
            tdo = pat_cur[idx];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] len_mask(input logic [4:0] len);
        return 32'hFFFF_FFFF >> (5'd31 - len);
    endfunction

    // Presents a command and returns right after the accepting clock edge.
    task automatic send_cmd(input string name, input logic [4:0] len, input logic [31:0] t_ms,
                            input logic [31:0] t_di, input bit do_trst);
        int n;
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_len_i   = len;
        bus.cmd_tms_i   = t_ms;
        bus.cmd_tdi_i   = t_di;
`ifdef JTAG_HOST_TRST_EN
        bus.cmd_trst_i  = do_trst;
`endif
        n = 0;
        while (!bus.cmd_ready_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check({name, " cmd_ready timeout"}, 32'(bus.cmd_ready_o), 32'd1);
        @(posedge clk); #1;
        // Scramble the command inputs: they must not be looked at after accept.
        bus.cmd_valid_i = 1'b0;
        bus.cmd_len_i   = 5'($urandom);
        bus.cmd_tms_i   = $urandom;
        bus.cmd_tdi_i   = $urandom;
`ifdef JTAG_HOST_TRST_EN
        bus.cmd_trst_i  = 1'b0;
`endif
    endtask

    task automatic run_cmd(input string name, input logic [4:0] len, input logic [31:0] t_ms,
                           input logic [31:0] t_di, input logic [31:0] pat,
                           input logic [31:0] exp_tdo, input bit do_trst, input int hold);
        int n, hi, first_hi, rises, trst_lo, bad, busy_cnt;
        logic prev_tck;
        logic [31:0] o_tms, o_tdi, m;
        exp_t e;
        sb.push_back('{exp_tdo, do_trst ? 1 + 2 * CLK_DIV : 1 + (int'(len) + 1) * 2 * CLK_DIV});
        pat_cur = pat;
        base    = rise_cnt;
        send_cmd(name, len, t_ms, t_di, do_trst);
        n = 0; hi = 0; first_hi = 0; rises = 0; trst_lo = 0; prev_tck = 1'b0;
        o_tms = '0; o_tdi = '0;
        do begin
            @(negedge clk);
            n++;
            if (tck) begin
                hi++;
                if (first_hi == 0) first_hi = n;
                if (!prev_tck && rises < 32) begin
                    o_tms[rises[4:0]] = tms;
                    o_tdi[rises[4:0]] = tdi;
                    rises++;
                end
            end
            prev_tck = tck;
`ifdef JTAG_HOST_TRST_EN
            if (!trst_n) trst_lo++;
`endif
        end while (!bus.rsp_valid_o && n < 2000);
        e = sb.pop_front();
        check({name, " latency"}, n, e.lat);
        check({name, " rsp_tdo"}, bus.rsp_tdo_o, e.tdo);
        check({name, " busy in DONE"}, 32'(busy), 32'd1);
        m = len_mask(len);
        if (!do_trst) begin
            check({name, " tck high cycles"}, hi, (int'(len) + 1) * CLK_DIV);
            check({name, " first tck high"}, first_hi, CLK_DIV + 1);
            check({name, " tms bits"}, o_tms & m, t_ms & m);
            check({name, " tdi bits"}, o_tdi & m, t_di & m);
        end else begin
            check({name, " tck high cycles"}, hi, 0);
            check({name, " tms held"}, 32'(tms), 32'd1);
            check({name, " trst low cycles"}, trst_lo, 2 * CLK_DIV);
        end
        if (hold > 0) begin
            bad = 0;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (i == 3) begin
                    bus.cmd_valid_i = 1'b1;
                    bus.cmd_len_i   = 5'd0;
                end
                if (i == 4) bus.cmd_valid_i = 1'b0;
                if (bus.rsp_valid_o !== 1'b1 || bus.rsp_tdo_o !== e.tdo ||
                    bus.cmd_ready_o !== 1'b0 || tck !== 1'b0) bad++;
            end
            check({name, " hold stable"}, bad, 0);
        end
        bus.rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready_i = 1'b0;
        @(negedge clk);
        check({name, " rsp_valid after handshake"}, 32'(bus.rsp_valid_o), 32'd0);
        check({name, " cmd_ready after handshake"}, 32'(bus.cmd_ready_o), 32'd1);
        busy_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (busy || tck) busy_cnt++;
        end
        check({name, " idle after response"}, busy_cnt, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cnt;
        vecs[0] = '{5'd0,  32'h0000_0001, 32'h0000_0000, 32'h0000_0001};
        vecs[1] = '{5'd7,  32'h0000_00A5, 32'h0000_003C, 32'hFFFF_FF5A};
        vecs[2] = '{5'd31, 32'h8000_0001, 32'hDEAD_BEEF, 32'h1234_5678};
        vecs[3] = '{5'd15, 32'h0000_0000, 32'hFFFF_0000, 32'hABCD_8001};
        vecs[4] = '{5'd1,  32'h0000_0002, 32'h0000_0001, 32'h0000_0002};
        vecs[5] = '{5'd30, 32'h5555_5555, 32'h7FFF_FFFF, 32'hFFFF_FFFF};

        bus.cmd_valid_i = 1'b0;
        bus.cmd_len_i   = '0;
        bus.cmd_tms_i   = '0;
        bus.cmd_tdi_i   = '0;
        bus.rsp_ready_i = 1'b0;
`ifdef JTAG_HOST_TRST_EN
        bus.cmd_trst_i  = 1'b0;
`endif
        #12;
        check("reset tck", 32'(tck), 32'd0);
        check("reset tms", 32'(tms), 32'd1);
        check("reset tdi", 32'(tdi), 32'd0);
        check("reset rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("reset rsp_tdo", bus.rsp_tdo_o, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
`ifdef JTAG_HOST_TRST_EN
        check("reset trst_n", 32'(trst_n), 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tck || !tms) cnt++;
        end
        check("idle after reset pins quiet", cnt, 0);
`ifdef JTAG_HOST_TRST_EN
        check("trst_n after reset", 32'(trst_n), 32'd1);
`endif

        for (int i = 0; i < 6; i++)
            run_cmd($sformatf("vec%0d", i), vecs[i].len, vecs[i].tms, vecs[i].tdi, vecs[i].pat,
                    vecs[i].pat & len_mask(vecs[i].len), 1'b0, 0);

        run_cmd("backpressure", 5'd3, 32'h0000_0009, 32'h0000_0006, 32'h0000_000B,
                32'h0000_000B, 1'b0, 10);

        // Reset during bit 3's TCK-high phase of an 8-bit command.
        pat_cur = 32'h0000_00FF;
        base    = rise_cnt;
        send_cmd("rst_mid", 5'd7, 32'h0000_0000, 32'h0000_00FF, 1'b0);
        n = 0;
        while (n < 30) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid tck high before reset", 32'(tck), 32'd1);
        check("rst_mid tms before reset", 32'(tms), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid tck", 32'(tck), 32'd0);
        check("rst_mid tms", 32'(tms), 32'd1);
        check("rst_mid tdi", 32'(tdi), 32'd0);
        check("rst_mid rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("rst_mid cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.rsp_valid_o || tck || busy) cnt++;
        end
        check("rst_mid no response", cnt, 0);
        run_cmd("after_rst", 5'd7, 32'h0000_0081, 32'h0000_00C3, 32'h0000_0096,
                32'h0000_0096, 1'b0, 0);

        use_tap = 1'b1;
        run_cmd("tap_reset", 5'd4, 32'h0000_001F, 32'h0, 32'h0, 32'h0, 1'b0, 0);
        run_cmd("tap_to_shift", 5'd3, 32'h0000_0002, 32'h0, 32'h0, 32'h0, 1'b0, 0);
        run_cmd("tap_idcode", 5'd31, 32'h8000_0000, 32'hCAFE_F00D, 32'h0, IDCODE, 1'b0, 0);
        check("tap ends in Exit1-DR", 32'(tap_st), 32'(EX1_DR));
        use_tap = 1'b0;

`ifdef JTAG_HOST_TRST_EN
        run_cmd("trst", 5'd0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
